// File: rtl/mix_columns_iter_if.sv
// Handshake bundle for the iterative MixColumns engine: input state/mode on a
// valid/ready pair, transformed state out on a second valid/ready pair.
interface mix_columns_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    // Upstream/downstream side (drives requests, consumes results)
    modport master (
        output in_valid,
        output in_state,
        output in_inv,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state
    );

    // Engine side
    modport slave (
        input  in_valid,
        input  in_state,
        input  in_inv,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state
    );
endinterface

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns engine. A 128-bit state is accepted
// whole, COLS_PER_CYCLE columns are transformed per clock in place, and the
// result is held on the output until downstream takes it.
module mix_columns_iter #(
    parameter int unsigned COLS_PER_CYCLE = 1,
    parameter int unsigned ENABLE_INV     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mix_columns_iter_if.slave bus,
    output logic              busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // Counter value of the final BUSY cycle (3, 1 or 0).
    localparam logic [1:0] LastCnt = 2'(4 / COLS_PER_CYCLE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } st_e;

    st_e          st_q, st_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] state_q, state_d;
    logic         inv_q, inv_d;

    logic [127:0] stepped;
    logic         accept;
    int unsigned  col_idx;
    logic [31:0]  col_new;

    // GF(2^8) doubling, reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant as a sum of xtime powers; k is always a
    // literal at the call sites so the masks fold away.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return ({8{k[0]}} & b) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
    endfunction

    // One output byte; b0..b3 are the column bytes already rotated so b0 meets
    // the leading coefficient (2 forward, 0E inverse).
    function automatic logic [7:0] row_mix(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3,
                                           input logic inv);
        if (inv) begin
            return gf_mul(b0, 4'he) ^ gf_mul(b1, 4'hb) ^ gf_mul(b2, 4'hd) ^ gf_mul(b3, 4'h9);
        end
        return gf_mul(b0, 4'h2) ^ gf_mul(b1, 4'h3) ^ b2 ^ b3;
    endfunction

    // Full column transform; row 0 is the most significant byte.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {row_mix(a0, a1, a2, a3, inv),
                row_mix(a1, a2, a3, a0, inv),
                row_mix(a2, a3, a0, a1, inv),
                row_mix(a3, a0, a1, a2, inv)};
    endfunction

    // Replace the columns addressed by the counter with their transform.
    always_comb begin
        stepped = state_q;
        col_idx = 0;
        col_new = '0;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col_idx = int'(cnt_q) * COLS_PER_CYCLE + k;
            col_new = mix_col(state_q[127 - 32 * col_idx -: 32], inv_q);
            stepped[127 - 32 * col_idx -: 32] = col_new;
        end
    end

    // Next-state logic and input handshake.
    always_comb begin
        st_d         = st_q;
        cnt_d        = cnt_q;
        state_d      = state_q;
        inv_d        = inv_q;
        accept       = 1'b0;
        bus.in_ready = 1'b0;

        unique case (st_q)
            StIdle: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
            end
            StBusy: begin
                state_d = stepped;
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == LastCnt) begin
                    st_d = StDone;
                end
            end
            StDone: begin
                // Result leaves and a new state may enter on the same edge.
                bus.in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        accept = 1'b1;
                    end else begin
                        st_d = StIdle;
                    end
                end
            end
            default: st_d = StIdle;
        endcase

        if (accept) begin
            st_d    = StBusy;
            cnt_d   = 2'd0;
            state_d = bus.in_state;
            // With the inverse disabled the mode is tied low so that logic is pruned.
            inv_d   = bus.in_inv & (ENABLE_INV != 0);
        end
    end

    // State, counter, data and mode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= StIdle;
            cnt_q   <= 2'd0;
            state_q <= '0;
            inv_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            inv_q   <= inv_d;
        end
    end

    // Status and output presentation.
    always_comb begin
        bus.out_valid = (st_q == StDone);
        bus.out_state = state_q;
        busy          = (st_q == StBusy);
    end

endmodule
